sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 22 ++
 rtl/sram_seq.sv | 133 +++++++++++++
 rtl/sram_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared encodings and default widths for the two-master SRAM arbiter.
package sram_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_WR1  = 3'd3,
    ST_WR2  = 3'd4,
    ST_WR3  = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_seq.sv
// SRAM strobe/tristate sequencer: one read (RD1,RD2) or write (WR1..WR3) per start,
// followed by a DONE cycle. Strobes are registered from the next state so they line up with it.
module sram_seq
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_be,
  output logic                o_idle_c,
  output logic                o_rd_sample_c,
  output logic                o_done_c,
  output logic                o_busy,
  output logic                o_drive,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [ADDR_W-1:0]   o_ram_addr,
  output logic [DATA_W/8-1:0] o_ram_be_n,
  output logic                o_ram_ce_n,
  output logic                o_ram_oe_n,
  output logic                o_ram_we_n
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DATA_W/8-1:0] r_be;
  logic [DATA_W/8-1:0] w_be_sel;
  logic [DATA_W/8-1:0] r_be_n;
  logic [DATA_W/8-1:0] w_be_n_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_we_n;
  logic                r_drive;
  logic                r_busy;
  logic                w_ce_n_nxt;
  logic                w_oe_n_nxt;
  logic                w_we_n_nxt;
  logic                w_drive_nxt;
  logic                w_accept;

  assign w_accept = i_start && (r_state == ST_IDLE);
  assign w_be_sel = w_accept ? i_be : r_be;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = i_we ? ST_WR1 : ST_RD1;
      ST_RD1:  w_state_nxt = ST_RD2;
      ST_RD2:  w_state_nxt = ST_DONE;
      ST_WR1:  w_state_nxt = ST_WR2;
      ST_WR2:  w_state_nxt = ST_WR3;
      ST_WR3:  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobe values for the state being entered
  always_comb begin
    w_ce_n_nxt  = 1'b1;
    w_oe_n_nxt  = 1'b1;
    w_we_n_nxt  = 1'b1;
    w_be_n_nxt  = '1;
    w_drive_nxt = 1'b0;
    case (w_state_nxt)
      ST_RD1, ST_RD2: begin
        w_ce_n_nxt = 1'b0;
        w_oe_n_nxt = 1'b0;
        w_be_n_nxt = '0;
      end
      ST_WR1, ST_WR3: begin
        w_ce_n_nxt  = 1'b0;
        w_be_n_nxt  = ~w_be_sel;
        w_drive_nxt = 1'b1;
      end
      ST_WR2: begin
        w_ce_n_nxt  = 1'b0;
        w_we_n_nxt  = 1'b0;
        w_be_n_nxt  = ~w_be_sel;
        w_drive_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_be    <= '0;
      r_be_n  <= '1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_drive <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_be_n  <= w_be_n_nxt;
      r_ce_n  <= w_ce_n_nxt;
      r_oe_n  <= w_oe_n_nxt;
      r_we_n  <= w_we_n_nxt;
      r_drive <= w_drive_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_accept) begin
        r_be    <= i_be;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
    end
  end

  assign o_idle_c      = (r_state == ST_IDLE);
  assign o_rd_sample_c = (r_state == ST_RD2);
  assign o_done_c      = (r_state == ST_RD2) || (r_state == ST_WR3);
  assign o_busy        = r_busy;
  assign o_drive       = r_drive;
  assign o_wdata       = r_wdata;
  assign o_ram_addr    = r_addr;
  assign o_ram_be_n    = r_be_n;
  assign o_ram_ce_n    = r_ce_n;
  assign o_ram_oe_n    = r_oe_n;
  assign o_ram_we_n    = r_we_n;

endmodule

// File: rtl/sram_arbiter.sv
// Two-master async SRAM arbiter: m0 fetch reads, m1 data reads/writes.
// Fixed priority m1 > m0 by default; define SRAM_ARB_RR_EN for round-robin on ties.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ack,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ack,
  inout  wire  [DATA_W-1:0]   ram_data,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W/8-1:0] ram_be_n,
  output logic                ram_ce_n,
  output logic                ram_oe_n,
  output logic                ram_we_n,
  output logic                owner,
  output logic                busy
);

  logic              w_grant_m1;
  logic              w_start;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic              w_idle_c;
  logic              w_rd_sample_c;
  logic              w_done_c;
  logic              w_drive;
  logic [DATA_W-1:0] w_ram_wdata;
  logic              r_owner;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;

`ifdef SRAM_ARB_RR_EN
  logic r_rr_ptr;

  // On a tie the master that did not own the bus last time wins
  always_comb begin
    w_grant_m1 = m1_req;
    if (m0_req && m1_req) w_grant_m1 = (r_rr_ptr == OWN_M0);
  end

  always_ff @(posedge clk) begin
    if (rst)          r_rr_ptr <= OWN_M0;
    else if (w_start) r_rr_ptr <= w_grant_m1;
  end
`else
  assign w_grant_m1 = m1_req;
`endif

  assign w_start = w_idle_c && (m0_req || m1_req);
  assign w_we    = w_grant_m1 && m1_we;
  assign w_addr  = w_grant_m1 ? m1_addr : m0_addr;

  sram_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_seq (
    .clk           (clk),
    .rst           (rst),
    .i_start       (w_start),
    .i_we          (w_we),
    .i_addr        (w_addr),
    .i_wdata       (m1_wdata),
    .i_be          (m1_be),
    .o_idle_c      (w_idle_c),
    .o_rd_sample_c (w_rd_sample_c),
    .o_done_c      (w_done_c),
    .o_busy        (busy),
    .o_drive       (w_drive),
    .o_wdata       (w_ram_wdata),
    .o_ram_addr    (ram_addr),
    .o_ram_be_n    (ram_be_n),
    .o_ram_ce_n    (ram_ce_n),
    .o_ram_oe_n    (ram_oe_n),
    .o_ram_we_n    (ram_we_n)
  );

  assign ram_data = w_drive ? w_ram_wdata : {DATA_W{1'bz}};

  // Ack lands in DONE; read data is captured from the bus on the edge leaving RD2
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWN_M0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      if (w_start) r_owner <= w_grant_m1;
      r_m0_ack <= w_done_c && (r_owner == OWN_M0);
      r_m1_ack <= w_done_c && (r_owner == OWN_M1);
      if (w_rd_sample_c) begin
        if (r_owner == OWN_M1) r_m1_rdata <= ram_data;
        else                   r_m0_rdata <= ram_data;
      end
    end
  end

  assign owner    = r_owner;
  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;

endmodule
